ppu_packer: RTL and testbench
=============================

# ppu_packer

Post-processing and packing stage directly downstream of the PE array. It consumes 32-bit signed partial sums (opsum) from the last PE of a column over a valid/ready handshake. Each psum goes through optional ReLU, rounding right shift and int8 saturation. Four results are packed into one 32-bit ofmap word for the GLB write path, and a flush request emits a partially filled word with a byte mask.

## Interface
- DATA_BITS, 32, width of psum input and packed ofmap output; the block is defined only for 32.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- relu_en  in  1  1 = clamp negative psums to 0 before shifting; static while the block is busy.
- i_scale  in  5  right-shift amount 0..31; static while the block is busy.
- psum  in  DATA_BITS  signed partial sum from the PE array.
- psum_valid  in  1  psum is valid.
- psum_ready  out  1  block accepts psum this cycle (combinational).
- flush_valid  in  1  request to emit the current partial word.
- flush_ready  out  1  flush accepted this cycle (combinational).
- ofmap  out  DATA_BITS  packed word; lane k = bits [8k+7:8k].
- ofmap_mask  out  4  lane k holds a valid byte.
- ofmap_valid  out  1  ofmap/ofmap_mask valid.
- ofmap_ready  in  1  downstream accepts the word.

## Operation
- Quantize (combinational on the accepted psum):
  - x = (relu_en && psum<0) ? 0 : psum, sign-extended to 33 bits.
  - If i_scale>0, add 1<<(i_scale-1) (round half up); then arithmetic shift right by i_scale.
  - Saturate to [-128,127] and take the two's-complement byte.
- Pack register: pack_data[23:0] plus cnt (0..3) count the bytes held. Bytes fill lane 0 first, in arrival order.
- psum handshake fires when psum_valid && psum_ready:
  - cnt<3: byte is written to lane cnt and cnt increments.
  - cnt==3: the full word {byte, pack_data[23:0]} is loaded into the output register with mask 4'hF, and cnt returns to 0.
- out_free = !ofmap_valid || ofmap_ready.
- psum_ready = (cnt<3) || out_free.
- flush_ready = out_free.
- Flush fires when flush_valid && flush_ready:
  - Partial word (including any byte accepted in the same cycle) is loaded into the output register, with unused lanes 0 and mask = (1<<n)-1, where n is the byte count. cnt returns to 0.
  - If n==0, nothing is emitted and ofmap_valid is unchanged apart from a normal ofmap handshake.
  - If the same-cycle psum makes a full word (cnt==3), that word is emitted with mask 4'hF and the flush adds nothing.
- Output register: cleared to not-valid on an ofmap handshake unless a new word loads in the same cycle; a same-cycle load replaces it (back-to-back words).
- States are implied by cnt and ofmap_valid: FILL (cnt 0..3) × OUT_EMPTY/OUT_FULL. No other FSM.

## Timing
- Reset (rst=0, asynchronous) clears:
  - cnt=0, pack_data=0.
  - ofmap=0, ofmap_mask=0, ofmap_valid=0.
  - Consequently psum_ready=1 and flush_ready=1 immediately.
- Reset mid-operation discards the partial word and any undelivered output word.
- Latency: the 4th byte accepted at edge N gives ofmap_valid=1 after edge N, i.e. visible in cycle N+1.
- Throughput: 1 psum per cycle sustained with ofmap_ready=1; one word every 4 cycles.
- Backpressure: ofmap, ofmap_mask and ofmap_valid hold stable while ofmap_valid && !ofmap_ready. Up to 3 more bytes are still accepted; the 4th stalls (psum_ready=0).
- ofmap_valid never depends combinationally on ofmap_ready.

## Test plan
- Quantize, relu_en=1, i_scale=4:
  - psums 565, -100, 5000, 0 -> one word 0x007F0023, mask 0xF, one cycle after the 4th accept.
- Quantize, relu_en=0:
  - i_scale=2, psums -100, -1000, 7, 0x7FFFFFFF -> 0x7F0280E7 (-25, sat -128, 2, sat 127).
  - i_scale=0: psum 0x7FFFFFFF -> byte 0x7F.
- Streaming, i_scale=0, relu_en=0, ofmap_ready=1:
  - psums 1..8 on consecutive cycles -> words 0x04030201 and 0x08070605, both mask 0xF, psum_ready constantly 1.
- Backpressure, i_scale=0:
  - ofmap_ready=0 after the first word -> psums 5,6,7 still accepted, the 4th is stalled with psum_ready=0, and ofmap holds 0x04030201.
  - Raising ofmap_ready delivers it, then 0x08070605.
- Flush, i_scale=0:
  - Bytes 1,2 then flush -> 0x00000201, mask 0x3.
  - Flush with cnt=0 -> no output.
  - Flush in the same cycle as the 3rd byte 3 -> 0x00030201, mask 0x7.
  - Flush in the same cycle as the 4th byte -> a single word with mask 0xF.
- Reset mid-operation:
  - rst=0 after 2 bytes while ofmap_valid=1 -> all outputs 0 immediately.
  - Next 4 psums 9,10,11,12 (i_scale=0) -> 0x0C0B0A09 with no stale bytes.

Source files
------------

// File: rtl/ppu_packer_if.sv
// Psum-in / flush / packed-ofmap-out handshake bundle for ppu_packer.
// The packer uses the slave view; whoever drives psums and sinks words uses the master view.
interface ppu_packer_if #(
    parameter int DATA_BITS = 32
) ();
    logic [DATA_BITS-1:0] psum;
    logic                 psum_valid;
    logic                 psum_ready;
    logic                 flush_valid;
    logic                 flush_ready;
    logic [DATA_BITS-1:0] ofmap;
    logic [3:0]           ofmap_mask;
    logic                 ofmap_valid;
    logic                 ofmap_ready;

    modport master (
        output psum, psum_valid, flush_valid, ofmap_ready,
        input  psum_ready, flush_ready, ofmap, ofmap_mask, ofmap_valid
    );

    modport slave (
        input  psum, psum_valid, flush_valid, ofmap_ready,
        output psum_ready, flush_ready, ofmap, ofmap_mask, ofmap_valid
    );
endinterface

// File: rtl/ppu_packer.sv
// Quantizes signed psums (ReLU, rounding shift, int8 saturation) and packs four
// bytes per ofmap word; a flush emits the partially filled word with a lane mask.
module ppu_packer #(
    parameter int DATA_BITS = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         relu_en,
    input  logic [4:0]   i_scale,
    ppu_packer_if.slave  bus
);
    localparam int LANES = DATA_BITS / 8;
    localparam int XW    = DATA_BITS + 1;
    localparam logic signed [XW-1:0] SAT_MAX = 127;
    localparam logic signed [XW-1:0] SAT_MIN = -128;
    localparam logic [XW-1:0]        ONE     = 1;

    logic [1:0]            cnt_reg;
    logic [1:0]            cnt_next;
    logic [23:0]           pack_data_reg;
    logic [23:0]           pack_data_next;
    logic [DATA_BITS-1:0]  ofmap_reg;
    logic [DATA_BITS-1:0]  ofmap_next;
    logic [3:0]            mask_reg;
    logic [3:0]            mask_next;
    logic                  valid_reg;
    logic                  valid_next;

    logic                  out_free;
    logic                  psum_ready;
    logic                  psum_fire;
    logic                  flush_fire;
    logic [2:0]            fill_count;
    logic                  word_load;

    logic signed [XW-1:0]  x_ext;
    logic [XW-1:0]         round_bias;
    logic signed [XW-1:0]  rounded;
    logic signed [XW-1:0]  shifted;
    logic [7:0]            q_byte;

    logic [7:0]            merged_lane [LANES];
    logic [LANES-1:0]      lane_live;
    logic [DATA_BITS-1:0]  emit_word;

    // One extra bit keeps psum + rounding bias from overflowing before the shift.
    always_comb begin
        x_ext      = (relu_en && bus.psum[DATA_BITS-1]) ? '0 : {bus.psum[DATA_BITS-1], bus.psum};
        round_bias = (i_scale == 5'd0) ? '0 : (ONE << (i_scale - 5'd1));
        rounded    = x_ext + $signed(round_bias);
        shifted    = rounded >>> i_scale;
        if (shifted > SAT_MAX) begin
            q_byte = 8'h7f;
        end else if (shifted < SAT_MIN) begin
            q_byte = 8'h80;
        end else begin
            q_byte = shifted[7:0];
        end
    end

    always_comb begin
        out_free   = !valid_reg || bus.ofmap_ready;
        psum_ready = (cnt_reg != 2'(LANES - 1)) || out_free;
        psum_fire  = bus.psum_valid && psum_ready;
        flush_fire = bus.flush_valid && out_free;
        fill_count = {1'b0, cnt_reg} + {2'b00, psum_fire};
        // A completed word always emits; a flush emits only if something is held.
        word_load  = (fill_count == 3'(LANES)) || (flush_fire && fill_count != 3'd0);
    end

    // Per-lane view of the word as it would look after this cycle's accept.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            if (gi < LANES - 1) begin : g_held
                assign merged_lane[gi] = (psum_fire && cnt_reg == 2'(gi)) ? q_byte
                                                                          : pack_data_reg[8*gi +: 8];
                assign pack_data_next[8*gi +: 8] = word_load ? 8'h00 : merged_lane[gi];
            end else begin : g_top
                assign merged_lane[gi] = q_byte;
            end
            assign lane_live[gi]         = fill_count > 3'(gi);
            assign emit_word[8*gi +: 8]  = lane_live[gi] ? merged_lane[gi] : 8'h00;
        end
    endgenerate

    always_comb begin
        cnt_next   = word_load ? 2'd0 : fill_count[1:0];
        valid_next = word_load || (valid_reg && !bus.ofmap_ready);
        ofmap_next = word_load ? emit_word : ofmap_reg;
        mask_next  = word_load ? lane_live : mask_reg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg       <= 2'd0;
            pack_data_reg <= 24'd0;
            ofmap_reg     <= '0;
            mask_reg      <= 4'd0;
            valid_reg     <= 1'b0;
        end else begin
            cnt_reg       <= cnt_next;
            pack_data_reg <= pack_data_next;
            ofmap_reg     <= ofmap_next;
            mask_reg      <= mask_next;
            valid_reg     <= valid_next;
        end
    end

    assign bus.psum_ready  = psum_ready;
    assign bus.flush_ready = out_free;
    assign bus.ofmap       = ofmap_reg;
    assign bus.ofmap_mask  = mask_reg;
    assign bus.ofmap_valid = valid_reg;

endmodule

// File: tb/tb_ppu_packer.sv
// Bench for ppu_packer: directed scenarios plus random traffic, all checked
// against a byte-queue/word-queue model of quantize-and-pack.
module tb_ppu_packer;
    logic       clk = 1'b0;
    logic       rst;
    logic       relu_en;
    logic [4:0] i_scale;

    ppu_packer_if #(.DATA_BITS(32)) bus ();

    ppu_packer #(.DATA_BITS(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .relu_en (relu_en),
        .i_scale (i_scale),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int stalls   = 0;
    bit psum_acc;
    bit flush_acc;

    logic [7:0]  mb[$];
    logic [31:0] exp_w[$];
    logic [3:0]  exp_m[$];
    logic [31:0] got_w[$];
    logic [3:0]  got_m[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Quantize from the arithmetic definition: floor division after round-half-up bias.
    function automatic logic [7:0] model_q(input logic [31:0] p, input logic relu, input int s);
        longint x, d, q;
        x = longint'($signed(p));
        if (relu && x < 0) x = 0;
        if (s > 0) x = x + (longint'(1) << (s - 1));
        d = longint'(1) << s;
        q = x / d;
        if (x < 0 && (x % d) != 0) q = q - 1;
        if (q > 127) q = 127;
        else if (q < -128) q = -128;
        return q[7:0];
    endfunction

    task automatic model_emit();
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < mb.size(); i++) w = w | (32'(mb[i]) << (8 * i));
        exp_w.push_back(w);
        exp_m.push_back(4'((1 << mb.size()) - 1));
        mb.delete();
    endtask

    task automatic model_reset();
        mb.delete();
        exp_w.delete();
        exp_m.delete();
    endtask

    task automatic clear_log();
        got_w.delete();
        got_m.delete();
    endtask

    task automatic reset_check(input string tag);
        chk({tag, "_ofmap"}, bus.ofmap, 32'h0);
        chk({tag, "_mask"}, 32'(bus.ofmap_mask), 32'h0);
        chk({tag, "_valid"}, 32'(bus.ofmap_valid), 32'h0);
        chk({tag, "_psum_ready"}, 32'(bus.psum_ready), 32'h1);
        chk({tag, "_flush_ready"}, 32'(bus.flush_ready), 32'h1);
    endtask

    // One clock: check outputs against the model mid-cycle, then advance the model.
    task automatic cycle();
        logic exp_valid, exp_pr, exp_fr;
        @(negedge clk);
        exp_valid = (exp_w.size() != 0);
        exp_pr    = (mb.size() < 3) || !exp_valid || bus.ofmap_ready;
        exp_fr    = !exp_valid || bus.ofmap_ready;
        chk("ofmap_valid", 32'(bus.ofmap_valid), 32'(exp_valid));
        chk("psum_ready", 32'(bus.psum_ready), 32'(exp_pr));
        chk("flush_ready", 32'(bus.flush_ready), 32'(exp_fr));
        if (exp_valid) begin
            chk("ofmap", bus.ofmap, exp_w[0]);
            chk("ofmap_mask", 32'(bus.ofmap_mask), 32'(exp_m[0]));
            if (bus.ofmap_ready) begin
                $display("word ofmap=%08h mask=%h", bus.ofmap, bus.ofmap_mask);
                got_w.push_back(bus.ofmap);
                got_m.push_back(bus.ofmap_mask);
                void'(exp_w.pop_front());
                void'(exp_m.pop_front());
            end
        end
        psum_acc  = bus.psum_valid && exp_pr;
        flush_acc = bus.flush_valid && exp_fr;
        if (psum_acc) begin
            mb.push_back(model_q(bus.psum, relu_en, int'(i_scale)));
            if (mb.size() == 4) model_emit();
        end
        if (flush_acc && mb.size() > 0) model_emit();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] v, input bit with_flush);
        int n;
        n = 0;
        bus.psum        = v;
        bus.psum_valid  = 1'b1;
        bus.flush_valid = with_flush;
        do begin
            cycle();
            n++;
        end while (!psum_acc && n < 20);
        chk("send_accept", 32'(psum_acc), 32'h1);
        if (with_flush) chk("flush_with_psum", 32'(flush_acc), 32'h1);
        stalls += n - 1;
        bus.psum_valid  = 1'b0;
        bus.flush_valid = 1'b0;
    endtask

    task automatic do_flush();
        int n;
        n = 0;
        bus.flush_valid = 1'b1;
        do begin
            cycle();
            n++;
        end while (!flush_acc && n < 20);
        chk("flush_accept", 32'(flush_acc), 32'h1);
        bus.flush_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.psum_valid  = 1'b0;
        bus.flush_valid = 1'b0;
        repeat (n) cycle();
    endtask

    initial begin
        int n;
        rst             = 1'b0;
        relu_en         = 1'b0;
        i_scale         = 5'd0;
        bus.psum        = '0;
        bus.psum_valid  = 1'b0;
        bus.flush_valid = 1'b0;
        bus.ofmap_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_check("por");
        rst = 1'b1;

        // ReLU + shift by 4, with one saturating value
        relu_en = 1'b1; i_scale = 5'd4; clear_log();
        send(32'd565, 0); send(-32'sd100, 0); send(32'd5000, 0); send(32'd0, 0);
        chk("relu_latency", 32'(bus.ofmap_valid), 32'h1);
        idle(2);
        chk("relu_count", got_w.size(), 1);
        chk("relu_word", got_w[0], 32'h007F0023);
        chk("relu_mask", 32'(got_m[0]), 32'hF);

        // Negative rounding and saturation both ways
        relu_en = 1'b0; i_scale = 5'd2; clear_log();
        send(-32'sd100, 0); send(-32'sd1000, 0); send(32'd7, 0); send(32'h7FFFFFFF, 0);
        idle(2);
        chk("sat_word", got_w[0], 32'h7F0280E7);

        i_scale = 5'd0; clear_log();
        send(32'h7FFFFFFF, 0); do_flush(); idle(2);
        chk("scale0_word", got_w[0], 32'h0000007F);
        chk("scale0_mask", 32'(got_m[0]), 32'h1);

        // Streaming at full rate
        clear_log(); stalls = 0;
        for (int v = 1; v <= 8; v++) send(32'(v), 0);
        idle(2);
        chk("stream_stalls", stalls, 0);
        chk("stream_count", got_w.size(), 2);
        chk("stream_w0", got_w[0], 32'h04030201);
        chk("stream_w1", got_w[1], 32'h08070605);

        // Backpressure: three bytes accepted, the fourth stalls
        clear_log();
        for (int v = 1; v <= 4; v++) send(32'(v), 0);
        bus.ofmap_ready = 1'b0;
        stalls = 0;
        send(32'd5, 0); send(32'd6, 0); send(32'd7, 0);
        chk("bp_no_stall", stalls, 0);
        bus.psum = 32'd8; bus.psum_valid = 1'b1;
        cycle(); cycle();
        chk("bp_stall", 32'(bus.psum_ready), 32'h0);
        chk("bp_hold", bus.ofmap, 32'h04030201);
        chk("bp_none_out", got_w.size(), 0);
        bus.ofmap_ready = 1'b1;
        n = 0;
        do begin cycle(); n++; end while (!psum_acc && n < 20);
        chk("bp_release", 32'(psum_acc), 32'h1);
        idle(3);
        chk("bp_count", got_w.size(), 2);
        chk("bp_w0", got_w[0], 32'h04030201);
        chk("bp_w1", got_w[1], 32'h08070605);

        // Flush variants
        clear_log();
        send(32'd1, 0); send(32'd2, 0); do_flush(); idle(2);
        chk("flush2_word", got_w[0], 32'h00000201);
        chk("flush2_mask", 32'(got_m[0]), 32'h3);
        clear_log();
        do_flush(); idle(2);
        chk("flush0_count", got_w.size(), 0);
        clear_log();
        send(32'd1, 0); send(32'd2, 0); send(32'd3, 1); idle(2);
        chk("flush3_word", got_w[0], 32'h00030201);
        chk("flush3_mask", 32'(got_m[0]), 32'h7);
        clear_log();
        send(32'd1, 0); send(32'd2, 0); send(32'd3, 0); send(32'd4, 1); idle(3);
        chk("flush4_count", got_w.size(), 1);
        chk("flush4_word", got_w[0], 32'h04030201);
        chk("flush4_mask", 32'(got_m[0]), 32'hF);

        // Reset mid-operation with an undelivered word and two held bytes
        clear_log();
        for (int v = 1; v <= 4; v++) send(32'(v), 0);
        bus.ofmap_ready = 1'b0;
        send(32'd5, 0); send(32'd6, 0);
        chk("pre_rst_valid", 32'(bus.ofmap_valid), 32'h1);
        rst = 1'b0;
        #2;
        reset_check("mid");
        model_reset(); clear_log();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        bus.ofmap_ready = 1'b1;
        for (int v = 9; v <= 12; v++) send(32'(v), 0);
        idle(2);
        chk("post_rst_count", got_w.size(), 1);
        chk("post_rst_word", got_w[0], 32'h0C0B0A09);

        // Random traffic, configuration changed only while drained
        for (int seg = 0; seg < 6; seg++) begin
            relu_en = 1'($urandom_range(0, 1));
            i_scale = (seg == 5) ? 5'd31 : 5'($urandom_range(0, 10));
            for (int c = 0; c < 60; c++) begin
                bus.psum_valid = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 2) == 0) bus.psum = $urandom;
                else bus.psum = 32'(int'($urandom_range(0, 8000)) - 4000);
                bus.flush_valid = ($urandom_range(0, 7) == 0);
                bus.ofmap_ready = ($urandom_range(0, 3) != 0);
                cycle();
            end
            bus.psum_valid  = 1'b0;
            bus.ofmap_ready = 1'b1;
            do_flush();
            idle(3);
        end
        chk("final_drained", exp_w.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
